// File: rtl/operand_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch_unit
//  Purpose  : Decode-side register-file reader. Drives the read addresses,
//             captures operands into a one-entry output stage, tracks pending
//             writes in a busy-bit scoreboard, stalls on RAW/WAW hazards and
//             bypasses same-cycle writeback data.
//  Revision : 1.0  initial release
// ============================================================================
module operand_fetch_unit #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 6,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [AW-1:0]   in_rs1_i,
    input  logic [AW-1:0]   in_rs2_i,
    input  logic [AW-1:0]   in_rd_i,
    input  logic            in_rd_we_i,
    output logic [AW-1:0]   radr1_o,
    output logic [AW-1:0]   radr2_o,
    input  logic [XLEN-1:0] rdata1_i,
    input  logic [XLEN-1:0] rdata2_i,
    input  logic [AW-1:0]   wb_wadr_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            wb_wenable_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_op1_o,
    output logic [XLEN-1:0] out_op2_o,
    output logic [AW-1:0]   out_rd_o,
    output logic            out_rd_we_o,
    output logic [CNTW-1:0] stall_cnt_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NREG-1:0] busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_op1_q, out_op1_d;
    logic [XLEN-1:0] out_op2_q, out_op2_d;
    logic [AW-1:0]   out_rd_q, out_rd_d;
    logic            out_rd_we_q, out_rd_we_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // One-hot decodes of every address that touches the scoreboard.
    // Bit 0 (x0) is never tracked, and addresses >= NREG decode to all
    // zeros, so "tracked" is folded into the decode itself.
    // ------------------------------------------------------------------
    logic [NREG-1:0] rs1_dec;
    logic [NREG-1:0] rs2_dec;
    logic [NREG-1:0] rd_dec;
    logic [NREG-1:0] wb_dec;
    logic [NREG-1:0] out_rd_dec;

    assign rs1_dec[0]    = 1'b0;
    assign rs2_dec[0]    = 1'b0;
    assign rd_dec[0]     = 1'b0;
    assign wb_dec[0]     = 1'b0;
    assign out_rd_dec[0] = 1'b0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_dec
        localparam logic [AW-1:0] C_IDX = AW'(gi);
        assign rs1_dec[gi]    = (in_rs1_i  == C_IDX);
        assign rs2_dec[gi]    = (in_rs2_i  == C_IDX);
        assign rd_dec[gi]     = (in_rd_i   == C_IDX);
        assign wb_dec[gi]     = (wb_wadr_i == C_IDX);
        assign out_rd_dec[gi] = (out_rd_q  == C_IDX);
    end

    // ------------------------------------------------------------------
    // Writeback hits: any non-zero address matching an enabled writeback,
    // tracked or not, is forwarded and unblocks its source.
    // ------------------------------------------------------------------
    logic wb_hit_rs1;
    logic wb_hit_rs2;
    logic wb_hit_rd;

    assign wb_hit_rs1 = wb_wenable_i && (wb_wadr_i == in_rs1_i) && (in_rs1_i != '0);
    assign wb_hit_rs2 = wb_wenable_i && (wb_wadr_i == in_rs2_i) && (in_rs2_i != '0);
    assign wb_hit_rd  = wb_wenable_i && (wb_wadr_i == in_rd_i)  && (in_rd_i  != '0);

    // ------------------------------------------------------------------
    // Hazard detection: RAW on either source, WAW on the destination.
    // ------------------------------------------------------------------
    logic rs1_block;
    logic rs2_block;
    logic rd_block;
    logic hazard;
    logic accept;

    assign rs1_block = (|(busy_q & rs1_dec)) && !wb_hit_rs1;
    assign rs2_block = (|(busy_q & rs2_dec)) && !wb_hit_rs2;
    assign rd_block  = in_rd_we_i && (|(busy_q & rd_dec)) && !wb_hit_rd;
    assign hazard    = in_valid_i && (rs1_block || rs2_block || rd_block);

    assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Read addresses go straight through so the register file can answer
    // in the same cycle.
    assign radr1_o = in_rs1_i;
    assign radr2_o = in_rs2_i;

    // ------------------------------------------------------------------
    // Scoreboard update: clears first, then sets, so a register retired
    // and re-claimed in the same cycle ends up busy. A flushed instruction
    // that never reached execute releases its destination.
    // ------------------------------------------------------------------
    logic            flush_kill;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_set;

    assign flush_kill = flush_i && out_valid_q && out_rd_we_q && !out_ready_i;
    assign busy_clr   = (wb_wenable_i ? wb_dec : '0) | (flush_kill ? out_rd_dec : '0);
    assign busy_set   = (accept && in_rd_we_i) ? rd_dec : '0;
    assign busy_d     = (busy_q & ~busy_clr) | busy_set;

    // Next-state for the output stage: flush kills, accept loads,
    // consume empties, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_rd_d    = out_rd_q;
        out_rd_we_d = out_rd_we_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_op1_d   = wb_hit_rs1 ? wb_wdata_i : rdata1_i;
            out_op2_d   = wb_hit_rs2 ? wb_wdata_i : rdata2_i;
            out_rd_d    = in_rd_i;
            out_rd_we_d = in_rd_we_i;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating count of cycles spent in a hazard stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
            out_rd_we_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_rd_q    <= out_rd_d;
            out_rd_we_q <= out_rd_we_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_op1_o   = out_op1_q;
    assign out_op2_o   = out_op2_q;
    assign out_rd_o    = out_rd_q;
    assign out_rd_we_o = out_rd_we_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch_unit
//  Purpose  : Randomised plus directed stimulus for operand_fetch_unit with a
//             behavioural register-file / scoreboard reference model and a
//             queue-based output checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_fetch_unit;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 6;
    localparam int CNTW = 16;

    logic            clk;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [AW-1:0]   in_rd;
    logic            in_rd_we;
    logic [AW-1:0]   radr1;
    logic [AW-1:0]   radr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [AW-1:0]   wb_wadr;
    logic [XLEN-1:0] wb_wdata;
    logic            wb_wenable;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [AW-1:0]   out_rd;
    logic            out_rd_we;
    logic [CNTW-1:0] stall_cnt;

    operand_fetch_unit #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW),
        .CNTW (CNTW)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_rs1_i     (in_rs1),
        .in_rs2_i     (in_rs2),
        .in_rd_i      (in_rd),
        .in_rd_we_i   (in_rd_we),
        .radr1_o      (radr1),
        .radr2_o      (radr2),
        .rdata1_i     (rdata1),
        .rdata2_i     (rdata2),
        .wb_wadr_i    (wb_wadr),
        .wb_wdata_i   (wb_wdata),
        .wb_wenable_i (wb_wenable),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_op1_o    (out_op1),
        .out_op2_o    (out_op2),
        .out_rd_o     (out_rd),
        .out_rd_we_o  (out_rd_we),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file contents (x0 reads zero); written only at the clock edge.
    logic [XLEN-1:0] rf [64];
    assign rdata1 = rf[radr1];
    assign rdata2 = rf[radr2];

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [AW-1:0]   rd;
        logic            we;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit trk(input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < NREG);
    endfunction

    // Reference model: register file, busy set, held-instruction shadow and
    // stall counter, advanced once per cycle from the driven inputs.
    initial begin : model
        bit              mb [64];
        bit              ov_m;
        logic [AW-1:0]   hrd;
        bit              hwe;
        logic [CNTW-1:0] sc_m;
        bit              hit1, hit2, hitd, hz, rdy, acc;
        exp_t            e;
        for (int i = 0; i < 64; i++) begin
            rf[i] = (i == 0) ? '0 : $urandom;
            mb[i] = 1'b0;
        end
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        ov_m = 1'b0; hrd = '0; hwe = 1'b0; sc_m = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_op1", out_op1, 32'd0);
                check("rst_out_op2", out_op2, 32'd0);
                check("rst_out_rd", 32'(out_rd), 32'd0);
                check("rst_out_rd_we", 32'(out_rd_we), 32'd0);
                check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
                for (int i = 0; i < 64; i++) mb[i] = 1'b0;
                ov_m = 1'b0; hrd = '0; hwe = 1'b0; sc_m = '0;
                exp_q.delete();
                continue;
            end
            hit1 = wb_wenable && (wb_wadr == in_rs1) && (in_rs1 != 0);
            hit2 = wb_wenable && (wb_wadr == in_rs2) && (in_rs2 != 0);
            hitd = wb_wenable && (wb_wadr == in_rd)  && (in_rd  != 0);
            hz = in_valid && ((trk(in_rs1) && mb[in_rs1] && !hit1) ||
                              (trk(in_rs2) && mb[in_rs2] && !hit2) ||
                              (in_rd_we && trk(in_rd) && mb[in_rd] && !hitd));
            rdy = (!ov_m || out_ready) && !hz && !flush;
            check("in_ready", 32'(in_ready), 32'(rdy));
            check("out_valid", 32'(out_valid), 32'(ov_m));
            check("stall_cnt", 32'(stall_cnt), 32'(sc_m));
            check("radr1", 32'(radr1), 32'(in_rs1));
            check("radr2", 32'(radr2), 32'(in_rs2));
            acc = in_valid && rdy;
            if (acc) begin
                e.op1 = hit1 ? wb_wdata : rf[in_rs1];
                e.op2 = hit2 ? wb_wdata : rf[in_rs2];
                e.rd  = in_rd;
                e.we  = in_rd_we;
                exp_q.push_back(e);
            end
            if (wb_wenable && trk(wb_wadr)) mb[wb_wadr] = 1'b0;
            if (flush && ov_m && hwe && trk(hrd) && !out_ready) mb[hrd] = 1'b0;
            if (acc && in_rd_we && trk(in_rd)) mb[in_rd] = 1'b1;
            if (flush) begin
                ov_m = 1'b0;
            end else if (acc) begin
                ov_m = 1'b1; hrd = in_rd; hwe = in_rd_we;
            end else if (out_ready) begin
                ov_m = 1'b0;
            end
            if (hz && sc_m != 16'hFFFF) sc_m = sc_m + 16'd1;
            @(posedge clk);
            if (wb_wenable && wb_wadr != 0) rf[wb_wadr] = wb_wdata;
        end
    end

    // Output checker: compares the held instruction against the oldest
    // expectation every cycle it is presented, retiring it when consumed
    // or flushed.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL out_unexpected: actual out_valid=1 required no pending instruction (t=%0t)", $time);
                end else begin
                    e = exp_q[0];
                    check("out_op1", out_op1, e.op1);
                    check("out_op2", out_op2, e.op2);
                    check("out_rd", 32'(out_rd), 32'(e.rd));
                    check("out_rd_we", 32'(out_rd_we), 32'(e.we));
                    if (out_ready || flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit v, input int r1, input int r2, input int rd, input bit we,
                         input bit wbe, input int wba, input logic [XLEN-1:0] wbd,
                         input bit ordy, input bit fl);
        in_valid   = v;
        in_rs1     = AW'(r1);
        in_rs2     = AW'(r2);
        in_rd      = AW'(rd);
        in_rd_we   = we;
        wb_wenable = wbe;
        wb_wadr    = AW'(wba);
        wb_wdata   = wbd;
        out_ready  = ordy;
        flush      = fl;
        @(negedge clk);
    endtask

    task automatic rand_cycles(input int n);
        int r1, r2, rd;
        for (int k = 0; k < n; k++) begin
            r1 = ($urandom_range(0, 15) == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 9));
            r2 = ($urandom_range(0, 15) == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 9));
            rd = ($urandom_range(0, 15) == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 9));
            drive($urandom_range(0, 3) != 0, r1, r2, rd, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 4, int'($urandom_range(0, 10)), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
    endtask

    // Stimulus: reset, directed scenarios, random traffic, mid-run reset.
    initial begin : driver
        reset_n = 1'b0;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        wb_wenable = 1'b0; wb_wadr = '0; wb_wdata = '0; out_ready = 1'b1; flush = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Basic read of x3/x4.
        drive(1, 3, 4, 0, 0, 0, 0, 0, 1, 0);
        // Writer of x5, then a reader stalls until writeback bypasses it.
        drive(1, 1, 2, 5, 1, 0, 0, 0, 1, 0);
        repeat (3) drive(1, 5, 0, 6, 1, 0, 0, 0, 1, 0);
        drive(1, 5, 0, 6, 1, 1, 5, 32'hCAFE, 1, 0);
        // x0 and out-of-range destinations never become busy.
        drive(1, 1, 1, 0, 1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 10, 0, 0, 0, 0, 1, 0);
        drive(1, 1, 1, 32, 1, 0, 0, 0, 1, 0);
        drive(1, 32, 32, 32, 1, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 6, 32'h66, 1, 0);
        // Backpressure for three cycles, then flush releases x9.
        drive(1, 1, 2, 9, 1, 0, 0, 0, 0, 0);
        repeat (3) drive(1, 1, 2, 11, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 2, 11, 1, 0, 0, 0, 0, 1);
        drive(1, 9, 0, 12, 0, 0, 0, 0, 1, 0);
        // Writeback of x7 coincides with a new writer of x7: stays busy.
        drive(1, 1, 1, 7, 1, 0, 0, 0, 1, 0);
        drive(1, 1, 1, 7, 1, 1, 7, 32'h77, 1, 0);
        repeat (2) drive(1, 7, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 7, 0, 0, 0, 1, 7, 32'h7777, 1, 0);

        rand_cycles(600);

        // Asynchronous reset in the middle of traffic.
        reset_n = 1'b0;
        in_valid = 1'b0; wb_wenable = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        rand_cycles(300);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
